// File: rtl/ct_mat_lsu_pkg.sv
// Shared types and constants for the pipe8 matrix load/store row sequencer.
// Pure declarations: no latency and no flow control of its own.
package ct_mat_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CMPLT = 2'd3
    } seq_state_e;

    localparam int OP_W        = 2;
    localparam int ROW_BYTES_W = 19;
    localparam int OUTST_W     = 4;

    localparam logic [OP_W-1:0] MAT_LSU_LOAD  = 2'b01;
    localparam logic [OP_W-1:0] MAT_LSU_STORE = 2'b10;

    // A row of sizeK elements, each 2^elem_width bytes; 16+3 bits never overflow.
    function automatic logic [ROW_BYTES_W-1:0] calc_row_bytes(input logic [15:0] size_k,
                                                              input logic [1:0]  elem_width);
        calc_row_bytes = {3'b000, size_k} << elem_width;
    endfunction

endpackage

// File: rtl/ct_mat_lsu_addr_gen.sv
// 64-bit row address accumulator: load takes priority over increment, result valid next cycle.
// No flow control; the caller only asserts inc_i when a row is actually accepted.
module ct_mat_lsu_addr_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [63:0] base_i,
    input  logic        inc_i,
    input  logic [63:0] stride_i,
    output logic [63:0] addr_o
);

    logic [63:0] addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (load_i) begin
            addr_q <= base_i;
        end else if (inc_i) begin
            addr_q <= addr_q + stride_i;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/ct_mat_lsu_row_seq.sv
// Splits one matrix load/store into per-row memory requests and a single completion; first row N+1.
// Row requests hold payload under req_rdy backpressure; at most MAX_OUTST rows await responses.
module ct_mat_lsu_row_seq
    import ct_mat_lsu_pkg::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst,
    input  logic                   rtu_yy_xx_flush,
    input  logic                   ex1_vld,
    output logic                   ex1_rdy,
    input  logic [6:0]             ex1_iid,
    input  logic [OP_W-1:0]        ex1_op,
    input  logic [2:0]             ex1_mreg,
    input  logic [1:0]             ex1_elem_width,
    input  logic [63:0]            ex1_base,
    input  logic                   ex1_stride_vld,
    input  logic [63:0]            ex1_stride,
    input  logic [7:0]             x_sizeM,
    input  logic [15:0]            x_sizeK,
    output logic                   req_vld,
    input  logic                   req_rdy,
    output logic [OP_W-1:0]        req_op,
    output logic [2:0]             req_mreg,
    output logic [7:0]             req_row,
    output logic [63:0]            req_addr,
    output logic [ROW_BYTES_W-1:0] req_bytes,
    output logic                   req_last,
    input  logic                   rsp_vld,
    input  logic                   rsp_err,
    output logic                   cmplt_vld,
    output logic [6:0]             cmplt_iid,
    output logic                   cmplt_err,
    output logic                   busy
);

    localparam logic [OUTST_W-1:0] MAX_OUTST_C = OUTST_W'(MAX_OUTST);

    seq_state_e             state_q, state_d;
    logic [6:0]             iid_q, iid_d;
    logic [OP_W-1:0]        op_q, op_d;
    logic [2:0]             mreg_q, mreg_d;
    logic [ROW_BYTES_W-1:0] row_bytes_q, row_bytes_d;
    logic [63:0]            stride_q, stride_d;
    logic [7:0]             size_m_q, size_m_d;
    logic [7:0]             row_q, row_d;
    logic [OUTST_W-1:0]     outst_q, outst_d;
    logic                   err_q, err_d;

    logic                   accept_ex1;
    logic                   req_fire;
    logic                   rsp_take;
    logic [ROW_BYTES_W-1:0] ex1_row_bytes;

    assign ex1_row_bytes = calc_row_bytes(x_sizeK, ex1_elem_width);
    assign accept_ex1    = ex1_vld && (state_q == ST_IDLE) && !rtu_yy_xx_flush;
    assign req_vld       = (state_q == ST_ISSUE) && (outst_q < MAX_OUTST_C) && !err_q;
    assign req_fire      = req_vld && req_rdy;
    // Responses with nothing outstanding are protocol errors and are dropped.
    assign rsp_take      = rsp_vld && (outst_q != '0);
    assign req_last      = (state_q == ST_ISSUE) && (row_q == size_m_q - 8'd1);

    always_comb begin
        state_d     = state_q;
        iid_d       = iid_q;
        op_d        = op_q;
        mreg_d      = mreg_q;
        row_bytes_d = row_bytes_q;
        stride_d    = stride_q;
        size_m_d    = size_m_q;
        row_d       = req_fire ? row_q + 8'd1 : row_q;
        err_d       = err_q | (rsp_take & rsp_err);
        outst_d     = outst_q;
        if (req_fire && !rsp_take) begin
            outst_d = outst_q + 1'b1;
        end else if (!req_fire && rsp_take) begin
            outst_d = outst_q - 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept_ex1) begin
                    iid_d       = ex1_iid;
                    op_d        = ex1_op;
                    mreg_d      = ex1_mreg;
                    row_bytes_d = ex1_row_bytes;
                    stride_d    = ex1_stride_vld ? ex1_stride : {45'd0, ex1_row_bytes};
                    size_m_d    = x_sizeM;
                    row_d       = '0;
                    outst_d     = '0;
                    err_d       = 1'b0;
                    state_d     = (x_sizeM == 8'd0) ? ST_CMPLT : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (err_q || (req_fire && req_last)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((outst_q == '0) || ((outst_q == OUTST_W'(1)) && rsp_take)) begin
                    state_d = ST_CMPLT;
                end
            end
            ST_CMPLT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Memory side drops responses for flushed rows, so the window restarts empty.
        if (rtu_yy_xx_flush) begin
            state_d = ST_IDLE;
            row_d   = '0;
            outst_d = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q     <= ST_IDLE;
            iid_q       <= '0;
            op_q        <= '0;
            mreg_q      <= '0;
            row_bytes_q <= '0;
            stride_q    <= '0;
            size_m_q    <= '0;
            row_q       <= '0;
            outst_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            iid_q       <= iid_d;
            op_q        <= op_d;
            mreg_q      <= mreg_d;
            row_bytes_q <= row_bytes_d;
            stride_q    <= stride_d;
            size_m_q    <= size_m_d;
            row_q       <= row_d;
            outst_q     <= outst_d;
            err_q       <= err_d;
        end
    end

    ct_mat_lsu_addr_gen u_addr_gen (
        .clk      (forever_cpuclk),
        .rst      (cpurst),
        .load_i   (accept_ex1),
        .base_i   (ex1_base),
        .inc_i    (req_fire),
        .stride_i (stride_q),
        .addr_o   (req_addr)
    );

    assign ex1_rdy   = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign req_op    = op_q;
    assign req_mreg  = mreg_q;
    assign req_row   = row_q;
    assign req_bytes = row_bytes_q;
    assign cmplt_vld = (state_q == ST_CMPLT);
    assign cmplt_iid = iid_q;
    assign cmplt_err = err_q;

`ifndef SYNTHESIS
    rsp_needs_outst_a: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
        rsp_vld |-> (outst_q != '0));
    ex1_op_legal_a: assert property (@(posedge forever_cpuclk) disable iff (cpurst)
        (ex1_vld && ex1_rdy) |-> (ex1_op == MAT_LSU_LOAD || ex1_op == MAT_LSU_STORE));
`endif

endmodule

// File: tb/tb_ct_mat_lsu_row_seq.sv
// Directed bench for the matrix row sequencer: table of instructions plus window/flush sequences.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ct_mat_lsu_row_seq;
    import ct_mat_lsu_pkg::*;

    logic        forever_cpuclk = 1'b0;
    logic        cpurst;
    logic        rtu_yy_xx_flush;
    logic        ex1_vld;
    logic        ex1_rdy;
    logic [6:0]  ex1_iid;
    logic [1:0]  ex1_op;
    logic [2:0]  ex1_mreg;
    logic [1:0]  ex1_elem_width;
    logic [63:0] ex1_base;
    logic        ex1_stride_vld;
    logic [63:0] ex1_stride;
    logic [7:0]  x_sizeM;
    logic [15:0] x_sizeK;
    logic        req_vld;
    logic        req_rdy;
    logic [1:0]  req_op;
    logic [2:0]  req_mreg;
    logic [7:0]  req_row;
    logic [63:0] req_addr;
    logic [18:0] req_bytes;
    logic        req_last;
    logic        rsp_vld;
    logic        rsp_err;
    logic        cmplt_vld;
    logic [6:0]  cmplt_iid;
    logic        cmplt_err;
    logic        busy;

    always #5 forever_cpuclk = ~forever_cpuclk;

    ct_mat_lsu_row_seq #(.MAX_OUTST(4)) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .rtu_yy_xx_flush(rtu_yy_xx_flush),
        .ex1_vld        (ex1_vld),
        .ex1_rdy        (ex1_rdy),
        .ex1_iid        (ex1_iid),
        .ex1_op         (ex1_op),
        .ex1_mreg       (ex1_mreg),
        .ex1_elem_width (ex1_elem_width),
        .ex1_base       (ex1_base),
        .ex1_stride_vld (ex1_stride_vld),
        .ex1_stride     (ex1_stride),
        .x_sizeM        (x_sizeM),
        .x_sizeK        (x_sizeK),
        .req_vld        (req_vld),
        .req_rdy        (req_rdy),
        .req_op         (req_op),
        .req_mreg       (req_mreg),
        .req_row        (req_row),
        .req_addr       (req_addr),
        .req_bytes      (req_bytes),
        .req_last       (req_last),
        .rsp_vld        (rsp_vld),
        .rsp_err        (rsp_err),
        .cmplt_vld      (cmplt_vld),
        .cmplt_iid      (cmplt_iid),
        .cmplt_err      (cmplt_err),
        .busy           (busy)
    );

    typedef struct {
        logic [6:0]  iid;
        logic [1:0]  op;
        logic [2:0]  mreg;
        logic [1:0]  ew;
        logic [63:0] base;
        logic        sv;
        logic [63:0] stride;
        logic [7:0]  m;
        logic [15:0] k;
        int          rdy_mode;   // 0 always ready, 1 random, 2 never
        int          err_row;    // response index that carries rsp_err, -1 none
        int          exp_rows;
        logic [18:0] exp_bytes;
        logic [63:0] exp_stride;
        logic        exp_err;
        int          exp_lat;    // accept-to-cmplt cycles, -1 unchecked
    } vec_t;

    vec_t vecs[5];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    bit  auto_rsp = 1'b1;
    int  rsp_dly = 2;
    int  pend[$];
    int  rsp_idx;
    int  err_row = -1;
    int  rdy_mode = 0;
    bit  force_rsp = 1'b0;
    bit  err_seen;
    int  post_err_req;
    int  stab_fail;
    bit  hold_prev;
    logic [96:0] held;

    logic [63:0] cap_addr[$];
    logic [7:0]  cap_row[$];
    logic [18:0] cap_bytes[$];
    logic        cap_last[$];
    logic [1:0]  cap_op[$];
    logic [2:0]  cap_mreg[$];

    int          cmplt_n;
    logic [6:0]  c_iid;
    logic        c_err;
    int          c_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_capture();
        cap_addr.delete(); cap_row.delete(); cap_bytes.delete();
        cap_last.delete(); cap_op.delete(); cap_mreg.delete();
        pend.delete();
        cmplt_n = 0; rsp_idx = 0; err_seen = 1'b0; post_err_req = 0;
        stab_fail = 0; hold_prev = 1'b0;
    endtask

    task automatic set_instr(input vec_t v);
        ex1_iid = v.iid; ex1_op = v.op; ex1_mreg = v.mreg; ex1_elem_width = v.ew;
        ex1_base = v.base; ex1_stride_vld = v.sv; ex1_stride = v.stride;
        x_sizeM = v.m; x_sizeK = v.k;
    endtask

    // One cycle: drive inputs for the coming rising edge, record what the DUT shows, advance.
    task automatic step();
        rsp_vld = 1'b0;
        rsp_err = 1'b0;
        if (force_rsp) begin
            rsp_vld = 1'b1;
            force_rsp = 1'b0;
        end else if (auto_rsp && pend.size() > 0 && pend[0] <= cyc) begin
            void'(pend.pop_front());
            rsp_vld = 1'b1;
            rsp_err = (rsp_idx == err_row);
            rsp_idx++;
        end
        case (rdy_mode)
            0:       req_rdy = 1'b1;
            1:       req_rdy = 1'($urandom_range(0, 1));
            default: req_rdy = 1'b0;
        endcase
        if (req_vld) begin
            if (hold_prev && {req_addr, req_row, req_bytes, req_last, req_op, req_mreg} !== held)
                stab_fail++;
            if (err_seen) post_err_req++;
            if (req_rdy) begin
                cap_addr.push_back(req_addr); cap_row.push_back(req_row);
                cap_bytes.push_back(req_bytes); cap_last.push_back(req_last);
                cap_op.push_back(req_op); cap_mreg.push_back(req_mreg);
                if (auto_rsp) pend.push_back(cyc + rsp_dly);
            end
        end
        hold_prev = req_vld && !req_rdy;
        held = {req_addr, req_row, req_bytes, req_last, req_op, req_mreg};
        if (cmplt_vld) begin
            cmplt_n++; c_iid = cmplt_iid; c_err = cmplt_err; c_cyc = cyc;
        end
        if (rsp_vld && rsp_err) err_seen = 1'b1;
        @(negedge forever_cpuclk);
        cyc++;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int acc_cyc;
        int n;
        clear_capture();
        err_row = v.err_row;
        rdy_mode = v.rdy_mode;
        chk({nm, "_ex1_rdy_before"}, 64'(ex1_rdy), 64'd1);
        set_instr(v);
        ex1_vld = 1'b1;
        acc_cyc = cyc;
        step();
        ex1_vld = 1'b0;
        n = 0;
        while (cmplt_n == 0 && n < 300) begin
            step();
            n++;
        end
        step();
        chk({nm, "_cmplt_count"}, 64'(cmplt_n), 64'd1);
        chk({nm, "_ex1_rdy_after"}, 64'(ex1_rdy), 64'd1);
        chk({nm, "_rows"}, 64'(cap_addr.size()), 64'(v.exp_rows));
        for (int k = 0; k < cap_addr.size() && k < v.exp_rows; k++) begin
            chk($sformatf("%s_addr%0d", nm, k), cap_addr[k], v.base + 64'(k) * v.exp_stride);
            chk($sformatf("%s_row%0d", nm, k), 64'(cap_row[k]), 64'(k));
            chk($sformatf("%s_bytes%0d", nm, k), 64'(cap_bytes[k]), 64'(v.exp_bytes));
            chk($sformatf("%s_last%0d", nm, k), 64'(cap_last[k]), 64'(k == int'(v.m) - 1));
            chk($sformatf("%s_op%0d", nm, k), 64'(cap_op[k]), 64'(v.op));
            chk($sformatf("%s_mreg%0d", nm, k), 64'(cap_mreg[k]), 64'(v.mreg));
        end
        if (cmplt_n > 0) begin
            chk({nm, "_cmplt_iid"}, 64'(c_iid), 64'(v.iid));
            chk({nm, "_cmplt_err"}, 64'(c_err), 64'(v.exp_err));
            if (v.exp_lat >= 0) chk({nm, "_latency"}, 64'(c_cyc - acc_cyc), 64'(v.exp_lat));
        end
        chk({nm, "_payload_stable"}, 64'(stab_fail), 64'd0);
        chk({nm, "_no_req_after_err"}, 64'(post_err_req), 64'd0);
    endtask

    initial begin
        vecs[0] = '{iid: 7'h15, op: MAT_LSU_LOAD, mreg: 3'd3, ew: 2'd2, base: 64'h1000,
                    sv: 1'b0, stride: 64'hDEAD, m: 8'd3, k: 16'd4, rdy_mode: 0, err_row: -1,
                    exp_rows: 3, exp_bytes: 19'd16, exp_stride: 64'h10, exp_err: 1'b0, exp_lat: 6};
        vecs[1] = '{iid: 7'h22, op: MAT_LSU_STORE, mreg: 3'd5, ew: 2'd0, base: 64'h8000_0000_0000_0F00,
                    sv: 1'b1, stride: 64'h200, m: 8'd6, k: 16'd100, rdy_mode: 0, err_row: -1,
                    exp_rows: 6, exp_bytes: 19'd100, exp_stride: 64'h200, exp_err: 1'b0, exp_lat: 9};
        vecs[2] = '{iid: 7'h7F, op: MAT_LSU_LOAD, mreg: 3'd7, ew: 2'd3, base: 64'hFFFF_FFFF_FFFF_FFF0,
                    sv: 1'b0, stride: 64'h0, m: 8'd5, k: 16'd2, rdy_mode: 1, err_row: -1,
                    exp_rows: 5, exp_bytes: 19'd16, exp_stride: 64'h10, exp_err: 1'b0, exp_lat: -1};
        vecs[3] = '{iid: 7'h31, op: MAT_LSU_STORE, mreg: 3'd1, ew: 2'd1, base: 64'h2000,
                    sv: 1'b1, stride: 64'h40, m: 8'd5, k: 16'd8, rdy_mode: 0, err_row: 1,
                    exp_rows: 4, exp_bytes: 19'd16, exp_stride: 64'h40, exp_err: 1'b1, exp_lat: -1};
        vecs[4] = '{iid: 7'h0A, op: MAT_LSU_LOAD, mreg: 3'd0, ew: 2'd0, base: 64'h3000,
                    sv: 1'b0, stride: 64'h0, m: 8'd0, k: 16'd4, rdy_mode: 0, err_row: -1,
                    exp_rows: 0, exp_bytes: 19'd4, exp_stride: 64'h4, exp_err: 1'b0, exp_lat: 1};

        cpurst = 1'b1; rtu_yy_xx_flush = 1'b0; ex1_vld = 1'b0; req_rdy = 1'b0;
        rsp_vld = 1'b0; rsp_err = 1'b0;
        set_instr(vecs[0]);
        repeat (3) @(negedge forever_cpuclk);
        chk("rst_ex1_rdy", 64'(ex1_rdy), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_req_vld", 64'(req_vld), 64'd0);
        chk("rst_cmplt_vld", 64'(cmplt_vld), 64'd0);
        chk("rst_req_addr", req_addr, 64'd0);
        chk("rst_req_last", 64'(req_last), 64'd0);
        chk("rst_cmplt_iid", 64'(cmplt_iid), 64'd0);
        cpurst = 1'b0;
        @(negedge forever_cpuclk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Responses held off: the window of four must fill, then open one row per response.
        auto_rsp = 1'b0; rdy_mode = 0; err_row = -1;
        clear_capture();
        set_instr('{iid: 7'h44, op: MAT_LSU_LOAD, mreg: 3'd2, ew: 2'd2, base: 64'h4000,
                    sv: 1'b1, stride: 64'h200, m: 8'd6, k: 16'd4, rdy_mode: 0, err_row: -1,
                    exp_rows: 6, exp_bytes: 19'd16, exp_stride: 64'h200, exp_err: 1'b0, exp_lat: -1});
        ex1_vld = 1'b1; step(); ex1_vld = 1'b0;
        repeat (6) step();
        chk("win_rows_full", 64'(cap_addr.size()), 64'd4);
        chk("win_req_vld_full", 64'(req_vld), 64'd0);
        force_rsp = 1'b1; repeat (3) step();
        chk("win_rows_rel1", 64'(cap_addr.size()), 64'd5);
        chk("win_req_vld_rel1", 64'(req_vld), 64'd0);
        force_rsp = 1'b1; repeat (3) step();
        chk("win_rows_rel2", 64'(cap_addr.size()), 64'd6);
        for (int k = 0; k < cap_addr.size(); k++)
            chk($sformatf("win_addr%0d", k), cap_addr[k], 64'h4000 + 64'(k) * 64'h200);
        repeat (4) begin force_rsp = 1'b1; step(); end
        for (int n = 0; n < 10 && cmplt_n == 0; n++) step();
        chk("win_cmplt_count", 64'(cmplt_n), 64'd1);
        chk("win_cmplt_iid", 64'(c_iid), 64'h44);
        chk("win_cmplt_err", 64'(c_err), 64'd0);
        chk("win_stable", 64'(stab_fail), 64'd0);

        // Flush with two rows in flight.
        auto_rsp = 1'b1; rsp_dly = 20; rdy_mode = 0;
        clear_capture();
        set_instr('{iid: 7'h55, op: MAT_LSU_STORE, mreg: 3'd4, ew: 2'd2, base: 64'h9000,
                    sv: 1'b0, stride: 64'h0, m: 8'd8, k: 16'd4, rdy_mode: 0, err_row: -1,
                    exp_rows: 8, exp_bytes: 19'd16, exp_stride: 64'h10, exp_err: 1'b0, exp_lat: -1});
        ex1_vld = 1'b1; step(); ex1_vld = 1'b0;
        repeat (2) step();
        chk("fl_rows_before", 64'(cap_addr.size()), 64'd2);
        rdy_mode = 2; rtu_yy_xx_flush = 1'b1;
        step();
        rtu_yy_xx_flush = 1'b0;
        pend.delete(); hold_prev = 1'b0;
        chk("fl_req_vld", 64'(req_vld), 64'd0);
        chk("fl_busy", 64'(busy), 64'd0);
        chk("fl_ex1_rdy", 64'(ex1_rdy), 64'd1);
        chk("fl_cmplt_vld", 64'(cmplt_vld), 64'd0);
        repeat (5) step();
        chk("fl_no_cmplt", 64'(cmplt_n), 64'd0);
        rsp_dly = 2;
        run_vec(vecs[0], "post_flush");

        // Flush coinciding with ex1 valid: the instruction must not be taken.
        clear_capture(); rdy_mode = 0;
        set_instr(vecs[1]);
        ex1_vld = 1'b1; rtu_yy_xx_flush = 1'b1;
        step();
        ex1_vld = 1'b0; rtu_yy_xx_flush = 1'b0;
        chk("fla_busy", 64'(busy), 64'd0);
        chk("fla_req_vld", 64'(req_vld), 64'd0);
        repeat (3) step();
        chk("fla_no_rows", 64'(cap_addr.size()), 64'd0);
        chk("fla_no_cmplt", 64'(cmplt_n), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ct_mat_lsu_row_seq.md
# ct_mat_lsu_row_seq

Row sequencer for the matrix load/store pipe (pipe8). It accepts one decoded matrix load/store from the EX1 stage and breaks it into one memory request per matrix row. Row addresses come from base (src0), stride (src1, or packed row size) and the CFG-unit sizes. It tracks outstanding row responses and emits a single completion with the IID towards the RTU. It sits between the pipe8 EX1 register stage and the matrix memory port.

## Interface
- MAX_OUTST, 4: maximum rows issued but not yet responded (1..15).
- forever_cpuclk  in  1  clock; one clock; reset is asynchronous and active-high.
- cpurst  in  1  asynchronous active-high reset.
- rtu_yy_xx_flush  in  1  pipeline flush.
- ex1_vld  in  1  EX1 lsu instruction valid.
- ex1_rdy  out  1  sequencer can accept (high only in IDLE).
- ex1_iid  in  7  instruction id.
- ex1_op  in  2  01 load, 10 store.
- ex1_mreg  in  3  matrix register (dst for load, src2 for store).
- ex1_elem_width  in  2  log2 element bytes.
- ex1_base  in  64  base address (src0).
- ex1_stride_vld  in  1  src1 valid.
- ex1_stride  in  64  row stride in bytes.
- x_sizeM  in  8  rows.
- x_sizeK  in  16  elements per row.
- req_vld  out  1  row request valid.
- req_rdy  in  1  memory port accepts.
- req_op  out  2  copy of latched op.
- req_mreg  out  3  matrix register.
- req_row  out  8  row index.
- req_addr  out  64  row address.
- req_bytes  out  19  row byte count.
- req_last  out  1  final row of instruction.
- rsp_vld  in  1  one in-order response per accepted row.
- rsp_err  in  1  row faulted.
- cmplt_vld  out  1  single-cycle completion pulse.
- cmplt_iid  out  7  completed IID.
- cmplt_err  out  1  any row faulted.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ISSUE, DRAIN, CMPLT. All outputs reset to 0; state resets to IDLE. ex1_rdy is 1 after reset because it is combinational on IDLE.
- IDLE: on ex1_vld, latch iid, op, mreg, base and sizes.
  - row_bytes = {3'b0,x_sizeK} << elem_width.
  - stride = ex1_stride_vld ? ex1_stride : zero-extended row_bytes.
  - Clear counters and the error flag.
  - Go to ISSUE, or go to CMPLT when x_sizeM == 0 (no requests).
- ISSUE: req_vld = (outst < MAX_OUTST) && !err.
  - On req_vld&&req_rdy: addr += stride (mod 2^64), row += 1, outst += 1.
  - req_last = (row == sizeM-1).
  - After the last accepted row, go to DRAIN.
- rsp_vld decrements outst. When accept and response occur in the same cycle, outst is unchanged. A response with outst == 0 is a protocol violation (assertion) and is ignored.
- Error handling: rsp_err sets a sticky err. While err is set, no new rows are issued; ISSUE goes to DRAIN immediately.
- DRAIN: when outst == 0, or outst == 1 with rsp_vld in that cycle, go to CMPLT.
- CMPLT: cmplt_vld = 1 with the latched iid and err. Next state is IDLE.
- Flush in any state: next state is IDLE and counters and err are cleared. req_vld and cmplt_vld are 0 in the cycle after the flush. The memory side is required to drop responses for flushed rows, so no rsp_vld arrives after a flush. A flush in the same cycle as ex1 acceptance wins, and the instruction is not taken.
- Payload rule: req_* stay stable while req_vld && !req_rdy. req_vld is not withdrawn except by flush or by err.

## Timing
- Accept in cycle N; first req_vld in N+1, with req_addr = base.
- Back-to-back issue at one row per cycle while req_rdy = 1 and the window is not full.
- cmplt_vld in the cycle after the last response (or after the state change into CMPLT). The earliest completion for sizeM == 0 is N+1.
- ex1_rdy returns high the cycle after cmplt_vld.
- The sizes are sampled only at acceptance. Later CFG changes do not affect an instruction already in progress.

## Structure
- Package ct_mat_lsu_pkg holds:
  - state enum
  - MAT_LSU_LOAD = 2'b01 and MAT_LSU_STORE = 2'b10
  - op width 2
  - row-bytes width 19
- One sub-module, ct_mat_lsu_addr_gen: holds the 64-bit address accumulator with load (base) and increment (stride) controls.
- The outstanding counter is 4 bits wide.

## Test plan
- sizeM=3, sizeK=4, width=2, base=0x1000, no stride, req_rdy=1, responses 2 cycles later:
  - addr 0x1000, 0x1010, 0x1020 and bytes 16.
  - req_last on row 2.
  - One cmplt_vld with iid 0x15 and err=0.
- Stride 0x200, sizeM=6, MAX_OUTST=4, responses held off:
  - Exactly 4 requests issue, then req_vld=0.
  - Each rsp_vld releases one more row.
  - Addresses are base+k*0x200.
- req_rdy toggled randomly: payload is stable under backpressure, with no row skipped or duplicated.
- rsp_err on row 1 of 5:
  - No further rows issue after the error.
  - Outstanding rows drain.
  - cmplt_err=1.
- sizeM=0: no req_vld; cmplt_vld in N+1.
- Flush while in ISSUE with 2 rows outstanding:
  - Next cycle req_vld=0, busy=0, ex1_rdy=1.
  - No cmplt_vld.
  - A new instruction is accepted afterwards with clean counters.
